// File: rtl/aes_cipher_uart_tx.sv
// -----------------------------------------------------------------------------
// aes_cipher_uart_tx
//
// Purpose:
//   Captures one 128-bit AES ciphertext block on a single-cycle valid pulse
//   and sends it to the host as 16 back-to-back 8N1 UART frames. The most
//   significant byte goes first, and each byte is sent LSB first.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (must be >= 2)
//
// Ports:
//   clk           system clock, rising-edge active
//   reset         asynchronous, active-high reset
//   cypher_valid  one-cycle pulse qualifying cypher
//   cypher        128-bit ciphertext block
//   tx            UART serial line (idles high)
//   busy          high while a 16-byte transfer is in progress
//   done          one-cycle pulse after the last stop bit of byte 15
//   overrun       sticky: a block arrived while busy and was dropped
// -----------------------------------------------------------------------------
module aes_cipher_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cypher_valid,
  input  logic [127:0] cypher,
  output logic         tx,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state_q,    state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]     bit_idx_q,  bit_idx_d;
  logic [3:0]     byte_idx_q, byte_idx_d;
  logic [127:0]   shreg_q,    shreg_d;
  logic           tx_q,       tx_d;
  logic           busy_q,     busy_d;
  logic           done_q,     done_d;
  logic           overrun_q,  overrun_d;

  logic           baud_wrap;
  logic [7:0]     cur_byte;

  assign baud_wrap = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Next-state logic. The outputs are derived from the *next* state so that
  // the registered tx/busy change on the same edge as the state itself.
  always_comb begin
    // NOTE: every variable gets a default first; a branch that leaves one
    // unassigned would otherwise infer a latch.
    state_d    = state_q;
    baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q | (cypher_valid & busy_q);

    case (state_q)
      IDLE: begin
        if (cypher_valid) begin
          shreg_d    = cypher;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          baud_cnt_d = '0;   // restart the bit clock so the start bit is full length
          state_d    = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (byte_idx_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // The next byte always sits in the top 8 bits of the shift register.
            shreg_d    = shreg_q << 8;
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cur_byte = shreg_d[127:120];
    busy_d   = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_aes_cipher_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher_uart_tx
//
// Directed bench for aes_cipher_uart_tx with CLKS_PER_BIT = 4. A stream-level
// model (a 160-bit frame image indexed by time since accept) predicts every
// output each cycle; a mid-bit sampling receiver decodes the line so the
// byte sequence can be pinned against hand-written literals.
// -----------------------------------------------------------------------------
module tb_aes_cipher_uart_tx;

  localparam int C = 4;
  localparam int BLOCK_CYCLES = 160 * C;

  typedef logic [7:0] bytes_t [16];

  logic         clk;
  logic         reset;
  logic         cypher_valid;
  logic [127:0] cypher;
  logic         tx;
  logic         busy;
  logic         done;
  logic         overrun;

  aes_cipher_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .reset        (reset),
    .cypher_valid (cypher_valid),
    .cypher       (cypher),
    .tx           (tx),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!reset && done) done_cnt <= done_cnt + 1;

  // ---------------------------------------------------------------------------
  // Stream model: on accept, build the 160-bit line image of the whole block;
  // afterwards tx is simply image[t / C] where t counts cycles since accept.
  // ---------------------------------------------------------------------------
  logic m_stream [160];
  bit   m_active;
  int   m_t;
  logic exp_tx, exp_busy, exp_done, exp_ovr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
      exp_tx   <= 1'b1;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_ovr  <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (m_active) begin
        if (cypher_valid) exp_ovr <= 1'b1;
        if (m_t + 1 == BLOCK_CYCLES) begin
          m_active <= 1'b0;
          exp_done <= 1'b1;
          exp_busy <= 1'b0;
          exp_tx   <= 1'b1;
        end else begin
          m_t      <= m_t + 1;
          exp_busy <= 1'b1;
          exp_tx   <= m_stream[(m_t + 1) / C];
        end
      end else if (cypher_valid) begin
        for (int b = 0; b < 16; b++) begin
          m_stream[10*b] <= 1'b0;
          for (int i = 0; i < 8; i++) m_stream[10*b + 1 + i] <= cypher[120 - 8*b + i];
          m_stream[10*b + 9] <= 1'b1;
        end
        m_active <= 1'b1;
        m_t      <= 0;
        exp_busy <= 1'b1;
        exp_tx   <= 1'b0;
      end else begin
        exp_busy <= 1'b0;
        exp_tx   <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("cyc_tx",      tx,      exp_tx);
      check("cyc_busy",    busy,    exp_busy);
      check("cyc_done",    done,    exp_done);
      check("cyc_overrun", overrun, exp_ovr);
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver: detect a low level, move to mid-bit, sample 8 data bits and the
  // stop bit. Frames with a bad stop bit are dropped (shows up as a short list).
  // ---------------------------------------------------------------------------
  logic [7:0] rx_q [$];

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!reset && tx == 1'b0) begin
        repeat (C/2) @(negedge clk);
        b = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        if (tx == 1'b1) rx_q.push_back(b);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic pulse(input logic [127:0] d, output int k);
    cypher       = d;
    cypher_valid = 1'b1;
    @(negedge clk);
    cypher_valid = 1'b0;
    k = cyc;
  endtask

  task automatic wait_idle(output int endc);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", busy, 1'b0);
    endc = cyc;
  endtask

  task automatic finish_block(input int k);
    int e;
    wait_idle(e);
    check("busy_len",  e - k, BLOCK_CYCLES);
    check("done_end",  done,  1'b1);
    check("tx_at_end", tx,    1'b1);
  endtask

  task automatic check_rx(input bytes_t e);
    check("rx_count", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) check($sformatf("rx_byte%0d", i), rx_q[i], e[i]);
  endtask

  localparam logic [127:0] BLK_A = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] BLK_B = 128'h0123456789abcdeffedcba9876543210;

  bytes_t bytes_a = '{8'hff, 8'h0b, 8'h84, 8'h4a, 8'h08, 8'h53, 8'hbf, 8'h7c,
                      8'h69, 8'h34, 8'hab, 8'h43, 8'h64, 8'h14, 8'h8f, 8'hb9};
  bytes_t bytes_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd, 8'hef,
                      8'hfe, 8'hdc, 8'hba, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, dc;
    logic [9:0] lv;

    reset        = 1'b1;
    cypher_valid = 1'b0;
    cypher       = '0;
    repeat (3) @(negedge clk);
    check("rst_tx",      tx,      1'b1);
    check("rst_busy",    busy,    1'b0);
    check("rst_done",    done,    1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    repeat (5) @(negedge clk);

    // Full block A, with explicit bit timing of byte 1 (0x0b).
    rx_q.delete();
    pulse(BLK_A, k);
    check("accept_busy", busy, 1'b1);
    check("accept_tx",   tx,   1'b0);
    repeat (40 - 1) @(negedge clk);
    @(negedge clk);
    lv = 10'b1000010110;  // stop, bits 7..0 of 0x0b, start
    for (int j = 0; j < 40; j++) begin
      check($sformatf("byte1_lvl%0d", j), tx, lv[j / C]);
      @(negedge clk);
    end
    finish_block(k);
    check_rx(bytes_a);

    // Back-to-back: block B pulsed in the done cycle.
    rx_q.delete();
    pulse(BLK_B, k);
    check("b2b_tx_low", tx,   1'b0);
    check("b2b_busy",   busy, 1'b1);
    finish_block(k);
    check_rx(bytes_b);
    check("b2b_no_overrun", overrun, 1'b0);

    // Overrun: zero block offered at cycle 100 of a transfer.
    repeat (10) @(negedge clk);
    rx_q.delete();
    dc = done_cnt;
    pulse(BLK_A, k);
    repeat (99) @(negedge clk);
    check("ovr_before", overrun, 1'b0);
    cypher       = '0;
    cypher_valid = 1'b1;
    @(negedge clk);
    cypher_valid = 1'b0;
    check("ovr_after", overrun, 1'b1);
    finish_block(k);
    check_rx(bytes_a);
    repeat (2) @(negedge clk);
    check("ovr_one_done", done_cnt - dc, 1);

    // Reset during byte 5 with random input activity.
    repeat (10) @(negedge clk);
    pulse(BLK_B, k);
    repeat (204) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cypher       = {$urandom, $urandom, $urandom, $urandom};
      cypher_valid = (i == 4) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("pre_rst_overrun", overrun, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_tx",      tx,      1'b1);
    check("mid_rst_busy",    busy,    1'b0);
    check("mid_rst_done",    done,    1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    cypher_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dc = done_cnt;
    repeat (60) @(negedge clk);
    check("post_rst_no_done", done_cnt - dc, 0);
    check("post_rst_idle",    busy,          1'b0);

    // Fresh block after reset.
    rx_q.delete();
    pulse(BLK_A, k);
    finish_block(k);
    check_rx(bytes_a);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
